wb_arb2_mem_ctrl: RTL and testbench

Two-master to one-slave Wishbone B3 arbiter with round-robin grant and a per-access response watchdog. It sits in front of a single shared memory or slave, for example a BFM memory or RAM, and lets two masters (CPU and DMA) share it. Grant is held for the whole cyc_i assertion, so classic and incrementing bursts are never split. Accesses the slave fails to answer are terminated with err.

---
 rtl/wb_arb2_mem_ctrl_if.sv | 72 +++++++
 rtl/wb_arb2_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_wb_arb2_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arb2_mem_ctrl_if.sv
// Bus bundle for the two-master Wishbone B3 arbiter: both master ports, the
// shared slave port and the grant debug output.
interface wb_arb2_mem_ctrl_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  // master 0 request side
  logic [aw-1:0]   m0_adr_i;
  logic [dw-1:0]   m0_dat_i;
  logic [dw/8-1:0] m0_sel_i;
  logic            m0_we_i;
  logic [2:0]      m0_cti_i;
  logic [1:0]      m0_bte_i;
  logic            m0_cyc_i;
  logic            m0_stb_i;
  logic            m0_ack_o;
  logic            m0_err_o;
  logic            m0_rty_o;
  logic [dw-1:0]   m0_rdt_o;

  // master 1 request side
  logic [aw-1:0]   m1_adr_i;
  logic [dw-1:0]   m1_dat_i;
  logic [dw/8-1:0] m1_sel_i;
  logic            m1_we_i;
  logic [2:0]      m1_cti_i;
  logic [1:0]      m1_bte_i;
  logic            m1_cyc_i;
  logic            m1_stb_i;
  logic            m1_ack_o;
  logic            m1_err_o;
  logic            m1_rty_o;
  logic [dw-1:0]   m1_rdt_o;

  // shared slave side
  logic [aw-1:0]   s_adr_o;
  logic [dw-1:0]   s_dat_o;
  logic [dw/8-1:0] s_sel_o;
  logic            s_we_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_ack_i;
  logic            s_err_i;
  logic            s_rty_i;
  logic [dw-1:0]   s_rdt_i;

  logic [1:0]      grant_o;

  // Arbiter view
  modport slave (
    input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cti_i, m0_bte_i, m0_cyc_i, m0_stb_i,
    input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cti_i, m1_bte_i, m1_cyc_i, m1_stb_i,
    input  s_ack_i, s_err_i, s_rty_i, s_rdt_i,
    output m0_ack_o, m0_err_o, m0_rty_o, m0_rdt_o,
    output m1_ack_o, m1_err_o, m1_rty_o, m1_rdt_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
    output grant_o
  );

  // Environment view: the two masters plus the shared slave
  modport master (
    output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cti_i, m0_bte_i, m0_cyc_i, m0_stb_i,
    output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cti_i, m1_bte_i, m1_cyc_i, m1_stb_i,
    output s_ack_i, s_err_i, s_rty_i, s_rdt_i,
    input  m0_ack_o, m0_err_o, m0_rty_o, m0_rdt_o,
    input  m1_ack_o, m1_err_o, m1_rty_o, m1_rdt_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
    input  grant_o
  );
endinterface

// File: rtl/wb_arb2_mem_ctrl.sv
// Two-master Wishbone B3 arbiter: round-robin grant held for the whole cyc,
// with a response watchdog that terminates unanswered accesses with err.
module wb_arb2_mem_ctrl #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input logic               wb_clk_i,
  input logic               wb_rst_ni,
  wb_arb2_mem_ctrl_if.slave bus
);

  generate
    if (TIMEOUT < 0 || TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
      $error("wb_arb2_mem_ctrl: TIMEOUT must lie in 0 .. 2**TO_W-1");
    end
  endgenerate

  localparam bit            WD_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;

  logic owned;
  logic cyc_m, stb_m;
  logic resp;
  logic expire;

  assign owned = (state == OWN0) || (state == OWN1);
  assign resp  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  always_comb begin
    cyc_m = 1'b0;
    stb_m = 1'b0;
    case (state)
      OWN0: begin
        cyc_m = bus.m0_cyc_i;
        stb_m = bus.m0_stb_i;
      end
      OWN1: begin
        cyc_m = bus.m1_cyc_i;
        stb_m = bus.m1_stb_i;
      end
      default: ;
    endcase
  end

  // A slave response in the expiry cycle takes precedence over the forced err
  assign expire = WD_EN && owned && cyc_m && stb_m && !resp && (to_cnt == TO_LAST);

  always_comb begin
    to_cnt_nxt = '0;
    if (WD_EN && owned && cyc_m && stb_m && !resp && !expire)
      to_cnt_nxt = to_cnt + TO_W'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i)
          state_nxt = last ? OWN0 : OWN1;
        else if (bus.m0_cyc_i)
          state_nxt = OWN0;
        else if (bus.m1_cyc_i)
          state_nxt = OWN1;
      end
      OWN0:    if (!bus.m0_cyc_i) state_nxt = IDLE;
      OWN1:    if (!bus.m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state  <= IDLE;
      last   <= 1'b1;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      if (state == IDLE && state_nxt == OWN0)
        last <= 1'b0;
      else if (state == IDLE && state_nxt == OWN1)
        last <= 1'b1;
    end
  end

  // Slave-side mux and response routing; everything is zero while idle
  always_comb begin
    bus.s_adr_o  = '0;
    bus.s_dat_o  = '0;
    bus.s_sel_o  = '0;
    bus.s_we_o   = 1'b0;
    bus.s_cti_o  = '0;
    bus.s_bte_o  = '0;
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m0_rty_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    bus.m1_rty_o = 1'b0;
    case (state)
      OWN0: begin
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_cti_o  = bus.m0_cti_i;
        bus.s_bte_o  = bus.m0_bte_i;
        bus.s_cyc_o  = bus.m0_cyc_i & ~expire;
        bus.s_stb_o  = bus.m0_stb_i & ~expire;
        bus.m0_ack_o = bus.s_ack_i;
        bus.m0_err_o = bus.s_err_i | expire;
        bus.m0_rty_o = bus.s_rty_i;
      end
      OWN1: begin
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_cti_o  = bus.m1_cti_i;
        bus.s_bte_o  = bus.m1_bte_i;
        bus.s_cyc_o  = bus.m1_cyc_i & ~expire;
        bus.s_stb_o  = bus.m1_stb_i & ~expire;
        bus.m1_ack_o = bus.s_ack_i;
        bus.m1_err_o = bus.s_err_i | expire;
        bus.m1_rty_o = bus.s_rty_i;
      end
      default: ;
    endcase
  end

  assign bus.m0_rdt_o = bus.s_rdt_i;
  assign bus.m1_rdt_o = bus.s_rdt_i;
  assign bus.grant_o  = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_wb_arb2_mem_ctrl.sv
// Directed bench for wb_arb2_mem_ctrl: arbitration order, burst hold-off,
// watchdog expiry and asynchronous reset, with hand-computed expectations.
module tb_wb_arb2_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  wb_arb2_mem_ctrl_if #(.dw(32), .aw(32)) bus ();

  wb_arb2_mem_ctrl #(
    .dw(32),
    .aw(32),
    .TIMEOUT(8),
    .TO_W(16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked 2ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic m0_drive(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] adr, input logic [2:0] cti);
    bus.m0_cyc_i = cyc;
    bus.m0_stb_i = stb;
    bus.m0_we_i  = we;
    bus.m0_adr_i = adr;
    bus.m0_cti_i = cti;
  endtask

  task automatic m1_drive(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] adr, input logic [2:0] cti);
    bus.m1_cyc_i = cyc;
    bus.m1_stb_i = stb;
    bus.m1_we_i  = we;
    bus.m1_adr_i = adr;
    bus.m1_cti_i = cti;
  endtask

  initial begin
    m0_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    bus.m0_dat_i = '0;  bus.m0_sel_i = '0;  bus.m0_bte_i = '0;
    bus.m1_dat_i = '0;  bus.m1_sel_i = '0;  bus.m1_bte_i = '0;
    bus.s_ack_i  = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    bus.s_rdt_i  = 32'hCAFE_0001;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    settle();
    chk("rst_grant", bus.grant_o, 2'b00);
    chk("rst_s_cyc", bus.s_cyc_o, 1'b0);
    chk("rst_s_stb", bus.s_stb_o, 1'b0);
    chk("rst_m0_ack", bus.m0_ack_o, 1'b0);
    chk("rst_m1_err", bus.m1_err_o, 1'b0);

    // 1: m0 single write, slave acks in the second owned cycle
    step();
    m0_drive(1'b1, 1'b1, 1'b1, 32'h10, 3'b000);
    bus.m0_dat_i = 32'hDEAD_BEEF;
    bus.m0_sel_i = 4'hF;
    settle();
    chk("t1_arb_s_cyc", bus.s_cyc_o, 1'b0);
    step(); settle();
    chk("t1_grant", bus.grant_o, 2'b01);
    chk("t1_s_cyc", bus.s_cyc_o, 1'b1);
    chk("t1_s_adr", bus.s_adr_o, 32'h10);
    chk("t1_s_dat", bus.s_dat_o, 32'hDEAD_BEEF);
    chk("t1_s_we", bus.s_we_o, 1'b1);
    chk("t1_m0_ack_wait", bus.m0_ack_o, 1'b0);
    step();
    bus.s_ack_i = 1'b1;
    settle();
    chk("t1_m0_ack", bus.m0_ack_o, 1'b1);
    chk("t1_m1_ack", bus.m1_ack_o, 1'b0);
    chk("t1_m0_rdt", bus.m0_rdt_o, 32'hCAFE_0001);
    step();
    bus.s_ack_i = 1'b0;
    m0_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    settle();
    chk("t1_release_s_cyc", bus.s_cyc_o, 1'b0);
    chk("t1_m0_ack_once", bus.m0_ack_o, 1'b0);
    step(); settle();
    chk("t1_idle_grant", bus.grant_o, 2'b00);

    // 2: simultaneous request after reset -> m0 first, then m1, then m0
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m0_drive(1'b1, 1'b1, 1'b0, 32'h100, 3'b000);
    m1_drive(1'b1, 1'b1, 1'b0, 32'h200, 3'b000);
    settle();
    step(); settle();
    chk("t2_grant_m0", bus.grant_o, 2'b01);
    chk("t2_s_adr_m0", bus.s_adr_o, 32'h100);
    step();
    bus.s_ack_i = 1'b1;
    settle();
    chk("t2_m0_ack", bus.m0_ack_o, 1'b1);
    chk("t2_m1_ack_held", bus.m1_ack_o, 1'b0);
    step();
    bus.s_ack_i = 1'b0;
    m0_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    settle();
    chk("t2_m0_release", bus.s_cyc_o, 1'b0);
    step(); settle();
    chk("t2_gap_grant", bus.grant_o, 2'b00);
    chk("t2_gap_s_cyc", bus.s_cyc_o, 1'b0);
    step(); settle();
    chk("t2_grant_m1", bus.grant_o, 2'b10);
    chk("t2_s_adr_m1", bus.s_adr_o, 32'h200);
    step();
    bus.s_ack_i = 1'b1;
    settle();
    chk("t2_m1_ack", bus.m1_ack_o, 1'b1);
    chk("t2_m0_ack_idle", bus.m0_ack_o, 1'b0);
    step();
    bus.s_ack_i = 1'b0;
    m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    settle();
    step();
    m0_drive(1'b1, 1'b1, 1'b0, 32'h104, 3'b000);
    m1_drive(1'b1, 1'b1, 1'b0, 32'h204, 3'b000);
    settle();
    chk("t2_idle2_grant", bus.grant_o, 2'b00);
    step(); settle();
    chk("t2_rr_back_m0", bus.grant_o, 2'b01);
    step();
    m0_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    step();

    // 3: m1 four-beat incrementing burst, m0 requests mid-burst
    m1_drive(1'b1, 1'b1, 1'b1, 32'h40, 3'b010);
    settle();
    step(); settle();
    chk("t3_grant_m1", bus.grant_o, 2'b10);
    for (int unsigned b = 0; b < 4; b++) begin
      if (b != 0) step();
      m1_drive(1'b1, 1'b1, 1'b1, 32'h40 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
      if (b == 1) m0_drive(1'b1, 1'b1, 1'b0, 32'h500, 3'b000);
      bus.s_ack_i = 1'b1;
      settle();
      chk("t3_m1_ack", bus.m1_ack_o, 1'b1);
      chk("t3_m0_ack", bus.m0_ack_o, 1'b0);
      chk("t3_s_cyc", bus.s_cyc_o, 1'b1);
      chk("t3_s_adr", bus.s_adr_o, 32'h40 + 32'(4 * b));
      chk("t3_s_cti", bus.s_cti_o, (b == 3) ? 3'b111 : 3'b010);
    end
    step();
    bus.s_ack_i = 1'b0;
    m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    settle();
    chk("t3_release_s_cyc", bus.s_cyc_o, 1'b0);
    chk("t3_release_grant", bus.grant_o, 2'b10);
    step(); settle();
    chk("t3_gap_grant", bus.grant_o, 2'b00);
    step(); settle();
    chk("t3_grant_m0", bus.grant_o, 2'b01);
    chk("t3_s_adr_m0", bus.s_adr_o, 32'h500);
    step();
    m0_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    step();

    // 4: watchdog expiry on the 8th unanswered stb cycle, ownership kept
    m0_drive(1'b1, 1'b1, 1'b0, 32'h80, 3'b000);
    settle();
    for (int unsigned i = 1; i <= 8; i++) begin
      step(); settle();
      chk("t4_m0_err", bus.m0_err_o, (i == 8) ? 1'b1 : 1'b0);
      chk("t4_s_cyc", bus.s_cyc_o, (i == 8) ? 1'b0 : 1'b1);
      chk("t4_s_stb", bus.s_stb_o, (i == 8) ? 1'b0 : 1'b1);
    end
    step(); settle();
    chk("t4_kept_grant", bus.grant_o, 2'b01);
    chk("t4_kept_s_cyc", bus.s_cyc_o, 1'b1);
    chk("t4_kept_err", bus.m0_err_o, 1'b0);

    // 5: ack lands exactly on the expiry cycle -> ack wins, counter restarts
    repeat (6) step();
    step();
    bus.s_ack_i = 1'b1;
    settle();
    chk("t5_m0_ack", bus.m0_ack_o, 1'b1);
    chk("t5_m0_err", bus.m0_err_o, 1'b0);
    chk("t5_s_cyc", bus.s_cyc_o, 1'b1);
    for (int unsigned i = 1; i <= 8; i++) begin
      step();
      bus.s_ack_i = 1'b0;
      settle();
      chk("t5_restart_err", bus.m0_err_o, (i == 8) ? 1'b1 : 1'b0);
    end
    step();
    m0_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    step();

    // 6: asynchronous reset in the middle of an m1 burst
    m1_drive(1'b1, 1'b1, 1'b0, 32'h300, 3'b010);
    settle();
    step();
    bus.s_ack_i = 1'b1;
    settle();
    chk("t6_m1_ack_pre", bus.m1_ack_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_s_cyc", bus.s_cyc_o, 1'b0);
    chk("t6_async_s_stb", bus.s_stb_o, 1'b0);
    chk("t6_async_m1_ack", bus.m1_ack_o, 1'b0);
    chk("t6_async_grant", bus.grant_o, 2'b00);
    bus.s_ack_i = 1'b0;
    m0_drive(1'b1, 1'b1, 1'b0, 32'h600, 3'b000);
    step(); step();
    rst_n = 1'b1;
    settle();
    chk("t6_post_idle", bus.grant_o, 2'b00);
    step(); settle();
    chk("t6_m0_priority", bus.grant_o, 2'b01);
    chk("t6_s_adr", bus.s_adr_o, 32'h600);
    step();
    m0_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
